shift_pipe: RTL
===============

Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the 16-bit combinational shifter, which supports only logical and arithmetic right shift.
- Supports four modes: SLL, SRL, SRA, ROR.
- Generates a carry-out bit (last bit shifted out) and a zero flag.
- Uses a valid/ready handshake on both sides so it can sit between the execute-stage operand latch and the writeback buffer with backpressure.

Parameters:
- WIDTH, 16, data width; power of two, 8 to 64.
- AW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_vld  in  1  input operand valid
- in_rdy  out  1  shifter can accept input this cycle
- src  in  WIDTH  operand
- amt  in  AW  shift amount, 0..WIDTH-1
- mode  in  2  shift mode (shift_pkg::shift_mode_t)
- out_vld  out  1  result valid
- out_rdy  in  1  downstream accepts result
- res  out  WIDTH  shifted result
- cout  out  1  last bit shifted out
- zero  out  1  res == 0

Behaviour:
- Reset (rst_n low at a clk edge): all stage valid bits 0, all stage data/carry/mode registers 0; out_vld=0, res=0, cout=0, zero=0. Reset asserted mid-operation flushes every in-flight operation; none of them emerges afterwards.
- Pipeline: AW mux levels, level k shifts by 2^k when amt[k]=1.
  - A register follows each level, so latency is exactly AW cycles (4 for WIDTH=16) from the input handshake to out_vld.
  - Each stage carries its own copy of mode, the remaining amt bits, its valid bit and carry.
- Global stall: en = !out_vld || out_rdy; in_rdy = en.
  - When en=1, every stage register advances and stage 0 captures src/amt/mode with valid = in_vld.
  - When en=0, all stage registers hold.
  - Bubbles are not collapsed.
  - in_rdy depends only on registered out_vld and out_rdy; there is no combinational path from in_vld.
- Output stays stable (res/cout/zero held) while out_vld=1 and out_rdy=0.
- Mode semantics for shift n:
  - SLL: fill zeros from the LSB.
  - SRL: fill zeros from the MSB.
  - SRA: fill with src[WIDTH-1].
  - ROR: bits leaving the LSB re-enter at the MSB.
- Carry at each level where amt[k]=1 replaces the stage carry with the last bit moved out at that level:
  - SLL: bit [WIDTH-2^k] of the stage input.
  - SRL/SRA/ROR: bit [2^k-1] of the stage input.
  - Where amt[k]=0, the carry passes through unchanged.
  - Stage-0 carry input is 0, so amt=0 gives cout=0.
  - Net result: SLL cout=src[WIDTH-n]; right shifts and ROR cout=src[n-1].
- zero is computed from the final stage result and registered with res.
- Simultaneous events:
  - Input acceptance and output drain in the same cycle are both legal (full throughput of one result per cycle).
  - Mixed modes back-to-back are independent.
- Mode encoding 2'b11 is ROR. All encodings are legal; there is no illegal-mode state.

Decomposition:
- shift_pkg holds:
  - typedef enum logic [1:0] shift_mode_t {SLL=2'b00, SRL=2'b01, SRA=2'b10, ROR=2'b11}.
  - Helper constant for MIN/MAX WIDTH.
- One sub-module, shift_stage (params WIDTH, K):
  - Contents: one mux level plus its register (data, carry, mode, valid, amt bits), with an en input.
  - Instantiation: shift_pipe instantiates AW of them in a generate loop and drives the output ports from the final stage.

Test Plan:
- Reset: hold rst_n=0 with in_vld=1 for 3 cycles -> out_vld=0, res=0, cout=0, zero=0 throughout. Release -> first out_vld no earlier than 4 cycles after first accepted input.
- Latency/modes: src=16'hAEFF, amt=4:
  - SRA -> res=16'hFAEF, cout=1.
  - SRL -> 16'h0AEF, cout=1.
  - SLL -> 16'hEFF0, cout=0.
  - ROR -> 16'hFAEF, cout=1.
  - Each appears exactly 4 cycles after acceptance.
- Boundaries:
  - src=16'h8000 SRA amt=15 -> 16'hFFFF.
  - src=16'h001E SLL amt=0 -> 16'h001E, cout=0.
  - src=16'h0001 SRL amt=1 -> 16'h0000, zero=1, cout=1.
- Throughput/backpressure:
  - Stream the 6 operands {FFFF, AEFF, 0FFF, 001E, 0000, 1234} across all amt 0..15 and all modes, with out_rdy randomly low 30% of the time.
  - Compare against a scoreboard reference model: no drops, no duplicates, in order, output stable while stalled, in_rdy=0 exactly when out_vld && !out_rdy.
- Reset mid-flight: accept 3 operands, assert rst_n=0 for one cycle -> out_vld stays 0 and none of the 3 results ever appears.
- WIDTH=32 instance: src=32'h80000001 ROR amt=1 -> 32'hC0000000, cout=1, latency 5 cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and limits for the pipelined barrel shifter.
// The mode encoding is fixed so that every 2-bit value selects a legal mode.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_mode_t;

  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 64;

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One mux level of the barrel shifter (shift by 2^K when amt[K] is set)
// followed by its pipeline register; all registers hold while en is low.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 0,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vld,
  input  logic [WIDTH-1:0] data,
  input  logic             carry,
  input  shift_mode_t      mode,
  input  logic [AW-1:0]    amt,
  output logic             vld_q,
  output logic [WIDTH-1:0] data_q,
  output logic             carry_q,
  output logic             zero_q,
  output shift_mode_t      mode_q,
  output logic [AW-1:0]    amt_q
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] data_nxt;
  logic             carry_nxt;

  // The carry is the last bit pushed out at this level; an idle level keeps it.
  always_comb begin
    data_nxt  = data;
    carry_nxt = carry;
    if (amt[K]) begin
      case (mode)
        SLL: begin
          data_nxt  = data << S;
          carry_nxt = data[WIDTH-S];
        end
        SRL: begin
          data_nxt  = data >> S;
          carry_nxt = data[S-1];
        end
        SRA: begin
          data_nxt  = $signed(data) >>> S;
          carry_nxt = data[S-1];
        end
        default: begin
          data_nxt  = {data[S-1:0], data[WIDTH-1:S]};
          carry_nxt = data[S-1];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      mode_q  <= SLL;
      amt_q   <= '0;
    end else if (en) begin
      vld_q   <= vld;
      data_q  <= data_nxt;
      carry_q <= carry_nxt;
      zero_q  <= (data_nxt == '0);
      mode_q  <= mode;
      amt_q   <= amt;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: AW registered mux levels, SLL/SRL/SRA/ROR, carry-out
// and zero flag, valid/ready on both sides with a single global stall.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] src,
  input  logic [AW-1:0]    amt,
  input  logic [1:0]       mode,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             zero
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("shift_pipe: WIDTH must be a power of two between 8 and 64");
  end

  // Element 0 is the operand port side; element k+1 is the register after level k.
  logic             vld_s   [AW+1];
  logic [WIDTH-1:0] data_s  [AW+1];
  logic             carry_s [AW+1];
  logic             zero_s  [AW+1];
  shift_mode_t      mode_s  [AW+1];
  logic [AW-1:0]    amt_s   [AW+1];

  logic en;

  // Stall depends only on the registered output valid and downstream ready.
  assign en     = !out_vld || out_rdy;
  assign in_rdy = en;

  assign vld_s[0]   = in_vld;
  assign data_s[0]  = src;
  assign carry_s[0] = 1'b0;
  assign zero_s[0]  = 1'b0;
  assign mode_s[0]  = shift_mode_t'(mode);
  assign amt_s[0]   = amt;

  for (genvar k = 0; k < AW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .vld     (vld_s[k]),
      .data    (data_s[k]),
      .carry   (carry_s[k]),
      .mode    (mode_s[k]),
      .amt     (amt_s[k]),
      .vld_q   (vld_s[k+1]),
      .data_q  (data_s[k+1]),
      .carry_q (carry_s[k+1]),
      .zero_q  (zero_s[k+1]),
      .mode_q  (mode_s[k+1]),
      .amt_q   (amt_s[k+1])
    );
  end

  assign out_vld = vld_s[AW];
  assign res     = data_s[AW];
  assign cout    = carry_s[AW];
  assign zero    = zero_s[AW];

endmodule
